// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter for the mouse port.
// It sends one byte using the host-request sequence and reports the device's ACK/NACK or a timeout.
// The line outputs are open-drain style: 0 drives the line low, 1 releases it.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_TICKS = 700,
    parameter int unsigned TIMEOUT_TICKS = 105000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ce_7mp,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       done,
    output logic       ack_ok,
    output logic       timeout,
    output logic       rx_block,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_out,
    output logic       ps2_data_out
);

    localparam int unsigned INH_W = $clog2(INHIBIT_TICKS + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_TICKS);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_clk_meta;
    logic             r_clk_sync;
    logic             r_clk_prev;
    logic             r_data_meta;
    logic             r_data_sync;

    logic [9:0]       r_shift;
    logic [3:0]       r_bit_idx;
    logic [INH_W-1:0] r_inh_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_ack_res;

    logic             w_fall;
    logic             w_accept;
    logic             w_to_state;
    logic             w_finish;
    logic             w_to_expire;

    logic             w_clk_out_nxt;
    logic             w_data_out_nxt;
    logic             w_ready_nxt;
    logic             w_done_nxt;
    logic             w_ack_nxt;
    logic             w_to_nxt;
    logic             w_block_nxt;

    assign w_fall      = r_clk_prev & ~r_clk_sync;
    assign w_accept    = tx_valid & tx_ready & (r_state == S_IDLE);
    assign w_to_state  = (r_state == S_SHIFT) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_finish    = (r_state == S_WAIT_IDLE) && r_clk_sync && r_data_sync;
    // A falling edge in the same cycle as expiry wins; a clean finish also wins.
    assign w_to_expire = w_to_state && !w_fall && !w_finish && (r_to_cnt == TO_LAST);

    // Two-flop synchronizers for the raw lines plus the previous clock sample for edge detection
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= ps2_clk_in;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data_in;
            r_data_sync <= r_data_meta;
        end
    end

    // State register
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a timeout aborts any device-clocked state back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_inh_cnt == INH_LAST) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_fall && (r_bit_idx == 4'd9)) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (w_fall) begin
                    w_state_nxt = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (w_finish) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_to_expire) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Frame shifter, bit index, inhibit counter and ACK capture
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_shift   <= '1;
            r_bit_idx <= '0;
            r_inh_cnt <= '0;
            r_ack_res <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // Stop bit, odd parity, then data LSB first out of bit 0
                        r_shift   <= {1'b1, ~^tx_data, tx_data};
                        r_inh_cnt <= '0;
                        r_ack_res <= 1'b0;
                    end
                end
                S_INHIBIT: begin
                    if (ce_7mp && (r_inh_cnt != INH_LAST)) begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    r_bit_idx <= '0;
                end
                S_SHIFT: begin
                    if (w_fall) begin
                        r_shift   <= {1'b1, r_shift[9:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                    end
                end
                S_ACK: begin
                    if (w_fall) begin
                        r_ack_res <= ~r_data_sync;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Device-clock watchdog: cleared on entry to SHIFT and on every falling edge
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (r_state == S_REQ) begin
            r_to_cnt <= '0;
        end else if (w_to_state) begin
            if (w_fall) begin
                r_to_cnt <= '0;
            end else if (ce_7mp && (r_to_cnt != TO_LAST)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    // Output decode from the next state so registered outputs line up with the state register
    always_comb begin
        w_clk_out_nxt  = 1'b1;
        w_data_out_nxt = 1'b1;
        w_done_nxt     = 1'b0;
        w_ack_nxt      = ack_ok;
        w_to_nxt       = timeout;
        case (w_state_nxt)
            S_INHIBIT: begin
                w_clk_out_nxt = 1'b0;
            end
            S_REQ: begin
                w_clk_out_nxt  = 1'b0;
                w_data_out_nxt = 1'b0;
            end
            S_SHIFT: begin
                if (r_state == S_REQ) begin
                    w_data_out_nxt = 1'b0;
                end else if (w_fall) begin
                    w_data_out_nxt = r_shift[0];
                end else begin
                    w_data_out_nxt = ps2_data_out;
                end
            end
            default: begin
            end
        endcase
        if (w_finish) begin
            w_done_nxt = 1'b1;
            w_ack_nxt  = r_ack_res;
            w_to_nxt   = 1'b0;
        end else if (w_to_expire) begin
            w_done_nxt = 1'b1;
            w_ack_nxt  = 1'b0;
            w_to_nxt   = 1'b1;
        end
        // tx_ready is held off during the done cycle so it rises one cycle later
        w_ready_nxt = (w_state_nxt == S_IDLE) && !w_done_nxt;
        w_block_nxt = (w_state_nxt != S_IDLE);
    end

    // Output registers
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            ps2_clk_out  <= 1'b1;
            ps2_data_out <= 1'b1;
            tx_ready     <= 1'b1;
            done         <= 1'b0;
            ack_ok       <= 1'b0;
            timeout      <= 1'b0;
            rx_block     <= 1'b0;
        end else begin
            ps2_clk_out  <= w_clk_out_nxt;
            ps2_data_out <= w_data_out_nxt;
            tx_ready     <= w_ready_nxt;
            done         <= w_done_nxt;
            ack_ok       <= w_ack_nxt;
            timeout      <= w_to_nxt;
            rx_block     <= w_block_nxt;
        end
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter for the mouse port: it sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) to the device using the PS/2 host-request protocol, and returns the device's ACK/NACK result. It sits beside the PS2-to-Kempston receiver on the same clock/data lines and owns them only while a transfer is in progress. The line outputs are open-drain style: 0 drives the line low, 1 releases it. While it transmits, it asserts a block signal so the receiver can discard its shift contents.

## Interface
- INHIBIT_TICKS, 700: ce_7mp ticks the clock line is held low before the start bit (≈100 µs).
- TIMEOUT_TICKS, 105000: ce_7mp ticks allowed without a device clock falling edge (≈15 ms).
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- ce_7mp  in  1  clock enable, ≈7 MHz, used for all time-outs
- tx_valid  in  1  request to send tx_data
- tx_data  in  8  command byte
- tx_ready  out  1  high in IDLE only; a transfer is accepted on tx_valid & tx_ready
- done  out  1  one-cycle pulse when a transfer ends (success or failure)
- ack_ok  out  1  valid with done: 1 = device ACK, 0 = NACK or timeout
- timeout  out  1  valid with done: 1 = device clock timed out
- rx_block  out  1  high in every state except IDLE
- ps2_clk_in  in  1  raw clock line (asynchronous)
- ps2_data_in  in  1  raw data line (asynchronous)
- ps2_clk_out  out  1  0 = drive clock low, 1 = release
- ps2_data_out  out  1  0 = drive data low, 1 = release

## Operation
- Line inputs pass through two-flop synchronizers. A falling edge is synchronized previous = 1 and current = 0.
- Frame: start 0, D0..D7 LSB first, odd parity (parity = ~^tx_data), stop 1, device ACK.
- States:
  - IDLE: both lines released, tx_ready = 1. On accept, latch tx_data, compute parity, go to INHIBIT.
  - INHIBIT: clk_out = 0, data_out = 1. Count ce_7mp ticks; when the count reaches INHIBIT_TICKS, go to REQ.
  - REQ: one clk_sys cycle with clk_out = 0 and data_out = 0. Then release the clock, clear the timeout counter and bit index, and go to SHIFT.
  - SHIFT: on each falling edge, update data_out with the next bit:
    - edges 1–8: D0..D7
    - edge 9: parity
    - edge 10: release (stop bit); go to ACK.
  - ACK: on the next falling edge, sample the synchronized data line. 0 means ack_ok, 1 means NACK. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until both synchronized lines are high, then pulse done and return to IDLE.
- Timeout counter:
  - Cleared on every falling edge and on entry to SHIFT.
  - Increments on ce_7mp in SHIFT, ACK and WAIT_IDLE.
  - On reaching TIMEOUT_TICKS: release both lines, pulse done with ack_ok = 0 and timeout = 1, go to IDLE.
- ack_ok and timeout hold their values until the next done.
- tx_valid in any state other than IDLE is ignored; there is no queueing.

## Timing
- Reset values: ps2_clk_out = 1, ps2_data_out = 1, tx_ready = 1, done = 0, ack_ok = 0, timeout = 0, rx_block = 0, state = IDLE.
- All outputs are registered.
- Accept at cycle N: clk_out = 0, tx_ready = 0 and rx_block = 1 from cycle N+1.
- data_out falls exactly one cycle before clk_out releases.
- Bit updates occur 2–3 clk_sys cycles after the raw falling edge (synchronizer latency). This is well inside the device clock low phase.
- done is asserted for exactly one cycle. tx_ready rises in the cycle after done.
- Reset_n low in any state, including mid-frame, releases both lines in the next cycle with no done pulse.
- If a falling edge and a timeout expiry occur in the same cycle, the edge wins and the counter clears.

## Test plan
- **Send 0xF4 with a device model clocking at 12 kHz and ACKing:**
  - clk_out held low for 700 ce ticks.
  - Device samples bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - done with ack_ok = 1, timeout = 0.
- **Send 0xFF:** parity bit 1; data line sampled at the stop bit reads 1.
- **Device responds NACK (data high at the 11th falling edge):** done with ack_ok = 0, timeout = 0.
- **Device never clocks after REQ:** after 105000 ce ticks both lines are released, done with ack_ok = 0 and timeout = 1, tx_ready = 1.
- **reset_n asserted after the 5th falling edge:** next cycle ps2_clk_out = 1, ps2_data_out = 1, no done pulse. A new tx_valid with 0xF4 completes normally.
- **tx_valid pulsed during SHIFT with 0x00:** ignored, and the original byte completes unchanged.
